id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Decode stage directly downstream of the fetch stage.
- Owns the IF/ID buffer (PC, IR, predicted-branch flag, valid) and the 32-entry integer register file.
- Generates the immediate for the buffered instruction and detects load-use hazards.
- Produces operands for ID/EX and a stall request back to fetch; flushes on branch/jump redirect.

Parameters:
- BUBBLE_IR, 32'h0000_0000, IR value inserted on flush/bubble (matches fetch-stage squash value).
- NUM_REGS, 32, register-file depth; x0 hardwired zero.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pipeline_en  in  1  global advance; 0 freezes all state (memory wait).
- flush  in  1  branch/jump redirect from EX; squashes IF/ID contents.
- if_pc  in  32  PC of fetched instruction.
- if_ir  in  32  fetched instruction (already zeroed by fetch on redirect).
- if_pred_br  in  1  fetch predicted taken.
- ex_rd  in  5  destination of instruction in ID/EX.
- ex_is_load  in  1  ID/EX instruction is a load and valid.
- wb_ld  in  1  register-file write enable.
- wb_rd  in  5  write index.
- wb_data  in  32  write data.
- id_pc  out  32  buffered PC.
- id_ir  out  32  buffered IR; BUBBLE_IR when not valid or stalling.
- id_pred_br  out  1  buffered prediction flag.
- id_valid  out  1  instruction presented to ID/EX is real.
- rs1_data  out  32  operand 1.
- rs2_data  out  32  operand 2.
- imm  out  32  sign-extended immediate per opcode.
- stall_if  out  1  fetch must hold PC and not overwrite IF/ID.

Behaviour:
- Reset (reset=0, async): IF/ID PC=0, IR=BUBBLE_IR, pred=0, valid=0, state=RUN, all registers=0. All outputs are 0 (id_ir=BUBBLE_IR).
- IF/ID load: at posedge when pipeline_en=1 and state/stall allow. Captures if_pc, if_ir, if_pred_br; valid=1 iff if_ir!=BUBBLE_IR.
- Register read: combinational on buffered IR[19:15]/[24:20]. Index 0 always returns 0.
- Register write: at posedge when wb_ld=1 and wb_rd!=0. Independent of pipeline_en.
- Immediate, by opcode:
  - I-type for op_imm/op_load/op_jalr.
  - S-type for op_store.
  - B-type for op_br.
  - U-type for op_lui/op_auipc.
  - J-type for op_jal.
  - Otherwise 0.
- Hazard: hz = valid & ex_is_load & ex_rd!=0 & ((ex_rd==rs1) | (ex_rd==rs2 & opcode in {op_br, op_store, op_reg})).
- State machine:
  - RUN: if hz and !flush, stall_if=1, IF/ID held, id_valid=0, id_ir=BUBBLE_IR, next=STALL.
  - STALL: stall_if=0, outputs show held instruction, IF/ID loads normally, next=RUN. Exactly one bubble per load-use.
  - State advances only when pipeline_en=1. With pipeline_en=0, state and stall_if are held.
- flush=1 with pipeline_en=1: IF/ID loads BUBBLE_IR, valid=0, pred=0, next=RUN. Flush overrides hz.
- Latency: instruction captured at edge N is presented at ID outputs during cycle N+1.
- Reset mid-stall returns to RUN with an empty buffer.

Optional Feature:
- ID_WB_BYPASS_EN defined: rs1/rs2 reads return wb_data in the same cycle when wb_ld & wb_rd==read index & index!=0 (write-through).
- ID_WB_BYPASS_EN undefined: reads return the stored value. The new value is visible the cycle after the write; the EX forwarding network must cover the gap.

Decomposition:
- Shared package rv32i_types gains:
  - id_state_t enum {RUN, STALL}.
  - BUBBLE constant.
  - Immediate-type enum imm_sel_t.
- Existing rv32i_opcode values are reused.
- One sub-module, id_regfile: 2 read, 1 write, x0 zero, holds the bypass ifdef.

Test Plan:
- Reset low mid-run -> all outputs 0, id_ir=0, stall_if=0 immediately (async); registers read 0 after release.
- Load if_ir=32'h00A00093 (addi x1,x0,10), pc=0x60 -> next cycle id_pc=0x60, imm=10, id_valid=1.
- ex_is_load=1, ex_rd=5, IR=add x3,x5,x6 -> stall_if=1 one cycle, id_valid=0; next cycle same IR, id_valid=1, stall_if=0.
- Same hazard with flush=1 -> no stall, id_ir=0, id_valid=0, state RUN.
- pipeline_en=0 for 3 cycles during STALL -> stall_if stays 1, IF/ID unchanged; resumes correctly.
- wb_ld=1, wb_rd=7, wb_data=0xDEADBEEF, IR reads x7 -> with ID_WB_BYPASS_EN rs1_data=0xDEADBEEF same cycle, without it the prior value; write to x0 ignored.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I decode types: opcodes, immediate formats, ID-stage states and the bubble encoding.
package rv32i_types;

    localparam logic [6:0] op_lui   = 7'b0110111;
    localparam logic [6:0] op_auipc = 7'b0010111;
    localparam logic [6:0] op_jal   = 7'b1101111;
    localparam logic [6:0] op_jalr  = 7'b1100111;
    localparam logic [6:0] op_br    = 7'b1100011;
    localparam logic [6:0] op_load  = 7'b0000011;
    localparam logic [6:0] op_store = 7'b0100011;
    localparam logic [6:0] op_imm   = 7'b0010011;
    localparam logic [6:0] op_reg   = 7'b0110011;

    localparam logic [31:0] BUBBLE = 32'h0000_0000;

    typedef enum logic {RUN, STALL} id_state_t;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;

    function automatic imm_sel_t imm_sel_of(input logic [6:0] opcode);
        imm_sel_t sel;
        sel = IMM_NONE;
        case (opcode)
            op_imm, op_load, op_jalr: sel = IMM_I;
            op_store:                 sel = IMM_S;
            op_br:                    sel = IMM_B;
            op_lui, op_auipc:         sel = IMM_U;
            op_jal:                   sel = IMM_J;
            default:                  sel = IMM_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] gen_imm(input logic [31:0] ir);
        logic [31:0] val;
        val = '0;
        case (imm_sel_of(ir[6:0]))
            IMM_I:   val = {{20{ir[31]}}, ir[31:20]};
            IMM_S:   val = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   val = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_U:   val = {ir[31:12], 12'b0};
            IMM_J:   val = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: val = '0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Integer register file, 2 read / 1 write, x0 hardwired to zero.
// ID_WB_BYPASS_EN makes a same-cycle write visible on the read ports (write-through).
module id_regfile #(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [4:0]  wr_idx,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_idx1,
    input  logic [4:0]  rd_idx2,
    output logic [31:0] rd_data1,
    output logic [31:0] rd_data2
);

    logic [31:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en && wr_idx != 5'd0) begin
            regs[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data1 = (rd_idx1 == 5'd0) ? 32'd0 : regs[rd_idx1];
        rd_data2 = (rd_idx2 == 5'd0) ? 32'd0 : regs[rd_idx2];
`ifdef ID_WB_BYPASS_EN
        if (wr_en && wr_idx == rd_idx1 && rd_idx1 != 5'd0) rd_data1 = wr_data;
        if (wr_en && wr_idx == rd_idx2 && rd_idx2 != 5'd0) rd_data2 = wr_data;
`else
        // Writes land at the edge; EX forwarding covers the one-cycle gap.
`endif
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID buffer, register file, immediate generation and load-use stall.
// Optional write-through regfile reads with ID_WB_BYPASS_EN (see id_regfile).
//
// state | meaning
// RUN   | normal flow; a load-use hazard holds IF/ID and emits one bubble
// STALL | bubble already issued; held instruction goes out, IF/ID reloads
module id_stage import rv32i_types::*; #(
    parameter logic [31:0] BUBBLE_IR = BUBBLE,
    parameter int          NUM_REGS  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipeline_en,
    input  logic        flush,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_ir,
    input  logic        if_pred_br,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        wb_ld,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic [31:0] id_pc,
    output logic [31:0] id_ir,
    output logic        id_pred_br,
    output logic        id_valid,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] imm,
    output logic        stall_if
);

    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic        pred_q;
    logic        valid_q;
    id_state_t   state;

    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs2_used;
    logic        hz;

    assign opcode   = ir_q[6:0];
    assign rs1      = ir_q[19:15];
    assign rs2      = ir_q[24:20];
    assign rs2_used = (opcode == op_br) || (opcode == op_store) || (opcode == op_reg);

    // rs1 is compared for every opcode: a spurious stall is harmless, a missed one is not.
    assign hz = valid_q && ex_is_load && (ex_rd != 5'd0) &&
                ((ex_rd == rs1) || ((ex_rd == rs2) && rs2_used));

    assign stall_if = (state == RUN) && hz && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            ir_q    <= BUBBLE_IR;
            pred_q  <= 1'b0;
            valid_q <= 1'b0;
            state   <= RUN;
        end else if (pipeline_en) begin
            if (flush) begin
                pc_q    <= if_pc;
                ir_q    <= BUBBLE_IR;
                pred_q  <= 1'b0;
                valid_q <= 1'b0;
                state   <= RUN;
            end else if (stall_if) begin
                state   <= STALL;
            end else begin
                pc_q    <= if_pc;
                ir_q    <= if_ir;
                pred_q  <= if_pred_br;
                valid_q <= (if_ir != BUBBLE_IR);
                state   <= RUN;
            end
        end
    end

    assign id_pc      = pc_q;
    assign id_pred_br = pred_q;
    assign id_valid   = valid_q && !stall_if;
    assign id_ir      = id_valid ? ir_q : BUBBLE_IR;
    assign imm        = gen_imm(ir_q);

    id_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wb_ld),
        .wr_idx   (wb_rd),
        .wr_data  (wb_data),
        .rd_idx1  (rs1),
        .rd_idx2  (rs2),
        .rd_data1 (rs1_data),
        .rd_data2 (rs2_data)
    );

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage; expected values are hand-computed encodings.
module tb_id_stage;

    logic        clk;
    logic        reset;
    logic        pipeline_en;
    logic        flush;
    logic [31:0] if_pc;
    logic [31:0] if_ir;
    logic        if_pred_br;
    logic [4:0]  ex_rd;
    logic        ex_is_load;
    logic        wb_ld;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] id_pc;
    logic [31:0] id_ir;
    logic        id_pred_br;
    logic        id_valid;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        stall_if;

    int pass_cnt = 0;
    int total    = 0;

    localparam logic [31:0] ADDI_X1_X0_10  = 32'h00A0_0093;
    localparam logic [31:0] ADD_X3_X5_X6   = 32'h0062_81B3;
    localparam logic [31:0] ADD_X2_X1_X0   = 32'h0000_8133;
    localparam logic [31:0] ADD_X3_X7_X7   = 32'h0073_81B3;

    id_stage dut (
        .clk        (clk),
        .reset      (reset),
        .pipeline_en(pipeline_en),
        .flush      (flush),
        .if_pc      (if_pc),
        .if_ir      (if_ir),
        .if_pred_br (if_pred_br),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .wb_ld      (wb_ld),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .id_pc      (id_pc),
        .id_ir      (id_ir),
        .id_pred_br (id_pred_br),
        .id_valid   (id_valid),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .imm        (imm),
        .stall_if   (stall_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (id_ir !== 32'h0 || id_valid !== 1'b0 || stall_if !== 1'b0 || id_pc !== 32'h0 || imm !== 32'h0)
            $display("FAIL reset_init: ir=%h valid=%b stall=%b pc=%h imm=%h, want all 0", id_ir, id_valid, stall_if, id_pc, imm);
        else pass_cnt++;
        tick(); tick();
        reset = 1'b1;
        wb_ld = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
        if_ir = ADD_X2_X1_X0; if_pc = 32'h40; if_pred_br = 1'b1;
        tick();
        wb_ld = 1'b0; if_ir = 32'h0; if_pred_br = 1'b0;
        #1;
        total++;
        if (rs1_data !== 32'h55 || id_pc !== 32'h40 || id_pred_br !== 1'b1)
            $display("FAIL reset_prerun: rs1=%h pc=%h pred=%b, want 00000055 00000040 1", rs1_data, id_pc, id_pred_br);
        else pass_cnt++;
        #2 reset = 1'b0;
        #1;
        total++;
        if (id_pc !== 32'h0 || id_ir !== 32'h0 || id_valid !== 1'b0 || id_pred_br !== 1'b0 ||
            rs1_data !== 32'h0 || rs2_data !== 32'h0 || imm !== 32'h0 || stall_if !== 1'b0)
            $display("FAIL reset_async: pc=%h ir=%h valid=%b pred=%b rs1=%h stall=%b, want all 0",
                     id_pc, id_ir, id_valid, id_pred_br, rs1_data, stall_if);
        else pass_cnt++;
        tick();
        reset = 1'b1;
        if_ir = ADD_X2_X1_X0; if_pc = 32'h44;
        tick();
        if_ir = 32'h0;
        #1;
        total++;
        if (id_ir !== ADD_X2_X1_X0 || rs1_data !== 32'h0)
            $display("FAIL reset_regs: ir=%h rs1=%h, want %h 00000000", id_ir, rs1_data, ADD_X2_X1_X0);
        else pass_cnt++;
    endtask

    task automatic test_addi();
        if_ir = ADDI_X1_X0_10; if_pc = 32'h60; if_pred_br = 1'b1;
        tick();
        if_ir = 32'h0; if_pred_br = 1'b0;
        #1;
        total++;
        if (id_pc !== 32'h60 || imm !== 32'd10 || id_valid !== 1'b1 || id_ir !== ADDI_X1_X0_10 || id_pred_br !== 1'b1)
            $display("FAIL addi: pc=%h imm=%h valid=%b ir=%h pred=%b, want 00000060 0000000a 1 %h 1",
                     id_pc, imm, id_valid, id_ir, id_pred_br, ADDI_X1_X0_10);
        else pass_cnt++;
    endtask

    task automatic test_imm();
        logic [31:0] irs  [7];
        logic [31:0] exps [7];
        irs  = '{32'hFE51_2C23, 32'h1234_50B7, 32'hFE00_0EE3, 32'h0010_00EF,
                 32'h0062_81B3, 32'hFFF0_0093, 32'h8000_0097};
        exps = '{32'hFFFF_FFF8, 32'h1234_5000, 32'hFFFF_FFFC, 32'h0000_0800,
                 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        for (int i = 0; i < 7; i++) begin
            if_ir = irs[i];
            tick();
            #1;
            total++;
            if (imm !== exps[i])
                $display("FAIL imm_%0d: ir=%h imm=%h, want %h", i, irs[i], imm, exps[i]);
            else pass_cnt++;
        end
        if_ir = 32'h0;
    endtask

    task automatic test_no_hazard();
        if_ir = ADDI_X1_X0_10; if_pc = 32'h70;
        tick();
        if_ir = 32'h0;
        ex_is_load = 1'b1; ex_rd = 5'd10;
        #1;
        total++;
        if (stall_if !== 1'b0 || id_valid !== 1'b1)
            $display("FAIL nohz_rs2_itype: stall=%b valid=%b, want 0 1", stall_if, id_valid);
        else pass_cnt++;
        ex_rd = 5'd0;
        #1;
        total++;
        if (stall_if !== 1'b0 || id_valid !== 1'b1)
            $display("FAIL nohz_rd_x0: stall=%b valid=%b, want 0 1", stall_if, id_valid);
        else pass_cnt++;
        ex_is_load = 1'b0;
    endtask

    task automatic test_load_use();
        if_ir = ADD_X3_X5_X6; if_pc = 32'h80;
        tick();
        ex_is_load = 1'b1; ex_rd = 5'd5;
        if_ir = ADDI_X1_X0_10; if_pc = 32'h84;
        #1;
        total++;
        if (stall_if !== 1'b1 || id_valid !== 1'b0 || id_ir !== 32'h0)
            $display("FAIL lu_bubble: stall=%b valid=%b ir=%h, want 1 0 00000000", stall_if, id_valid, id_ir);
        else pass_cnt++;
        tick();
        total++;
        if (id_ir !== ADD_X3_X5_X6 || id_valid !== 1'b1 || stall_if !== 1'b0 || id_pc !== 32'h80)
            $display("FAIL lu_release: ir=%h valid=%b stall=%b pc=%h, want %h 1 0 00000080",
                     id_ir, id_valid, stall_if, id_pc, ADD_X3_X5_X6);
        else pass_cnt++;
        tick();
        ex_is_load = 1'b0; if_ir = 32'h0;
        #1;
        total++;
        if (id_pc !== 32'h84 || id_ir !== ADDI_X1_X0_10)
            $display("FAIL lu_next: pc=%h ir=%h, want 00000084 %h", id_pc, id_ir, ADDI_X1_X0_10);
        else pass_cnt++;
        if_ir = ADD_X3_X5_X6; if_pc = 32'h88;
        tick();
        ex_is_load = 1'b1; ex_rd = 5'd6; if_ir = 32'h0;
        #1;
        total++;
        if (stall_if !== 1'b1)
            $display("FAIL lu_rs2: stall=%b, want 1", stall_if);
        else pass_cnt++;
        tick();
        ex_is_load = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        if_ir = ADD_X3_X5_X6; if_pc = 32'h90; if_pred_br = 1'b1;
        tick();
        ex_is_load = 1'b1; ex_rd = 5'd5; flush = 1'b1;
        if_ir = ADDI_X1_X0_10;
        #1;
        total++;
        if (stall_if !== 1'b0)
            $display("FAIL flush_over_hz: stall=%b, want 0", stall_if);
        else pass_cnt++;
        tick();
        flush = 1'b0; if_ir = ADD_X3_X5_X6; if_pc = 32'h94; if_pred_br = 1'b0;
        #1;
        total++;
        if (id_ir !== 32'h0 || id_valid !== 1'b0 || id_pred_br !== 1'b0 || stall_if !== 1'b0)
            $display("FAIL flush_squash: ir=%h valid=%b pred=%b stall=%b, want 00000000 0 0 0",
                     id_ir, id_valid, id_pred_br, stall_if);
        else pass_cnt++;
        tick();
        total++;
        if (stall_if !== 1'b1 || id_pc !== 32'h94)
            $display("FAIL flush_resume: stall=%b pc=%h, want 1 00000094", stall_if, id_pc);
        else pass_cnt++;
        ex_is_load = 1'b0; if_ir = 32'h0;
        tick();
    endtask

    task automatic test_freeze();
        if_ir = ADD_X3_X5_X6; if_pc = 32'hA0;
        tick();
        ex_is_load = 1'b1; ex_rd = 5'd5; pipeline_en = 1'b0;
        if_ir = ADDI_X1_X0_10; if_pc = 32'hA4;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (stall_if !== 1'b1 || id_pc !== 32'hA0 || id_valid !== 1'b0)
                $display("FAIL freeze_hold_%0d: stall=%b pc=%h valid=%b, want 1 000000a0 0", i, stall_if, id_pc, id_valid);
            else pass_cnt++;
        end
        pipeline_en = 1'b1;
        tick();
        total++;
        if (id_ir !== ADD_X3_X5_X6 || id_valid !== 1'b1 || stall_if !== 1'b0)
            $display("FAIL freeze_resume: ir=%h valid=%b stall=%b, want %h 1 0", id_ir, id_valid, stall_if, ADD_X3_X5_X6);
        else pass_cnt++;
        pipeline_en = 1'b0;
        tick();
        total++;
        if (id_pc !== 32'hA0 || stall_if !== 1'b0)
            $display("FAIL freeze_in_stall: pc=%h stall=%b, want 000000a0 0", id_pc, stall_if);
        else pass_cnt++;
        pipeline_en = 1'b1; ex_is_load = 1'b0;
        tick();
        if_ir = 32'h0;
        #1;
        total++;
        if (id_pc !== 32'hA4 || id_ir !== ADDI_X1_X0_10)
            $display("FAIL freeze_next: pc=%h ir=%h, want 000000a4 %h", id_pc, id_ir, ADDI_X1_X0_10);
        else pass_cnt++;
    endtask

    task automatic test_wb();
        logic [31:0] exp_byp;
`ifdef ID_WB_BYPASS_EN
        exp_byp = 32'hDEAD_BEEF;
`else
        exp_byp = 32'h0000_0011;
`endif
        if_ir = ADD_X3_X7_X7; if_pc = 32'hB0;
        tick();
        if_ir = 32'h0; pipeline_en = 1'b0;
        wb_ld = 1'b1; wb_rd = 5'd7; wb_data = 32'h11;
        tick();
        wb_ld = 1'b0;
        #1;
        total++;
        if (rs1_data !== 32'h11 || rs2_data !== 32'h11 || id_ir !== ADD_X3_X7_X7)
            $display("FAIL wb_frozen: rs1=%h rs2=%h ir=%h, want 00000011 00000011 %h", rs1_data, rs2_data, id_ir, ADD_X3_X7_X7);
        else pass_cnt++;
        wb_ld = 1'b1; wb_data = 32'hDEAD_BEEF;
        #1;
        total++;
        if (rs1_data !== exp_byp || rs2_data !== exp_byp)
            $display("FAIL wb_same_cycle: rs1=%h rs2=%h, want %h", rs1_data, rs2_data, exp_byp);
        else pass_cnt++;
        tick();
        wb_ld = 1'b0;
        #1;
        total++;
        if (rs1_data !== 32'hDEAD_BEEF || rs2_data !== 32'hDEAD_BEEF)
            $display("FAIL wb_next_cycle: rs1=%h rs2=%h, want deadbeef", rs1_data, rs2_data);
        else pass_cnt++;
        pipeline_en = 1'b1; if_ir = ADDI_X1_X0_10;
        tick();
        if_ir = 32'h0; pipeline_en = 1'b0;
        wb_ld = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        #1;
        total++;
        if (rs1_data !== 32'h0)
            $display("FAIL wb_x0_same: rs1=%h, want 00000000", rs1_data);
        else pass_cnt++;
        tick();
        wb_ld = 1'b0;
        #1;
        total++;
        if (rs1_data !== 32'h0)
            $display("FAIL wb_x0_after: rs1=%h, want 00000000", rs1_data);
        else pass_cnt++;
        pipeline_en = 1'b1;
    endtask

    initial begin
        reset = 1'b0; pipeline_en = 1'b1; flush = 1'b0;
        if_pc = 32'h0; if_ir = 32'h0; if_pred_br = 1'b0;
        ex_rd = 5'd0; ex_is_load = 1'b0;
        wb_ld = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        test_reset();
        test_addi();
        test_imm();
        test_no_hazard();
        test_load_use();
        test_flush();
        test_freeze();
        test_wb();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
